// File: rtl/cz_pkg.sv
// cz_pkg: shared condition codes and pipeline flag entry for the C/Z flag unit
package cz_pkg;
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_C      = 2'b01;
    localparam logic [1:0] COND_Z      = 2'b10;
    localparam logic [1:0] COND_NZ     = 2'b11;

    typedef struct packed {
        logic c_we;
        logic z_we;
        logic zfm;
        logic c;
        logic z;
    } flag_entry_t;
endpackage

// File: rtl/cz_flag_unit_if.sv
// cz_flag_unit_if: EX-stage flag interface between the pipeline (master) and the flag unit (slave)
interface cz_flag_unit_if;
    logic       ex_valid;
    logic [1:0] ex_cond;
    logic       ex_c_we;
    logic       ex_z_we;
    logic       ex_z_from_mem;
    logic       ex_carry;
    logic       ex_zero;
    logic       mem_ld_zero;
    logic       stall_ex;
    logic       flush;
    logic       freeze;
    logic       ex_exec;
    logic       ex_carryin;
    logic       fwd_z;
    logic       c_flag;
    logic       z_flag;

    modport master (
        output ex_valid, ex_cond, ex_c_we, ex_z_we, ex_z_from_mem, ex_carry, ex_zero,
               mem_ld_zero, stall_ex, flush, freeze,
        input  ex_exec, ex_carryin, fwd_z, c_flag, z_flag
    );

    modport slave (
        input  ex_valid, ex_cond, ex_c_we, ex_z_we, ex_z_from_mem, ex_carry, ex_zero,
               mem_ld_zero, stall_ex, flush, freeze,
        output ex_exec, ex_carryin, fwd_z, c_flag, z_flag
    );
endinterface

// File: rtl/flag_stage_reg.sv
// flag_stage_reg: one pipeline flag entry; hold keeps it, bubble loads an empty entry
module flag_stage_reg
    import cz_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        bubble,
    input  flag_entry_t d,
    output flag_entry_t q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (!hold)
            q <= bubble ? '0 : d;
    end
endmodule

// File: rtl/cz_flag_unit.sv
// cz_flag_unit: tracks C/Z through EX/MEM and MEM/WB, forwards newest flags to EX,
// and commits them to the architectural flags.
module cz_flag_unit
    import cz_pkg::*;
#(
    parameter logic RESET_C = 1'b0,
    parameter logic RESET_Z = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    cz_flag_unit_if.slave bus
);
    flag_entry_t exmem_d, exmem_q, memwb_d, memwb_q;
    logic        exmem_z;

    function automatic logic cond_true(input logic [1:0] cond, input logic c, input logic z);
        return cond == COND_ALWAYS ? 1'b1 : cond == COND_C ? c : cond == COND_Z ? z : !z;
    endfunction

    // a load's Z is only known in MEM, so the EX/MEM entry forwards the live zero-detect
    assign exmem_z        = exmem_q.zfm ? bus.mem_ld_zero : exmem_q.z;
    assign bus.ex_carryin = exmem_q.c_we ? exmem_q.c : memwb_q.c_we ? memwb_q.c : bus.c_flag;
    assign bus.fwd_z      = exmem_q.z_we ? exmem_z : memwb_q.z_we ? memwb_q.z : bus.z_flag;
    assign bus.ex_exec    = bus.ex_valid && !bus.flush && cond_true(bus.ex_cond, bus.ex_carryin, bus.fwd_z);

    always_comb begin
        exmem_d = '{c_we: bus.ex_c_we, z_we: bus.ex_z_we, zfm: bus.ex_z_from_mem,
                    c: bus.ex_carry, z: bus.ex_zero};
        memwb_d = exmem_q;
        memwb_d.z = exmem_z;
    end

    flag_stage_reg u_exmem (
        .clk    (clk),
        .rst    (rst),
        .hold   (bus.freeze),
        .bubble (bus.stall_ex || bus.flush || !bus.ex_exec),
        .d      (exmem_d),
        .q      (exmem_q)
    );

    flag_stage_reg u_memwb (
        .clk    (clk),
        .rst    (rst),
        .hold   (bus.freeze),
        .bubble (bus.flush),
        .d      (memwb_d),
        .q      (memwb_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.c_flag <= RESET_C;
            bus.z_flag <= RESET_Z;
        end else if (!bus.freeze) begin
            if (memwb_q.c_we) bus.c_flag <= memwb_q.c;
            if (memwb_q.z_we) bus.z_flag <= memwb_q.z;
        end
    end
endmodule
